// File: rtl/frame_buffer_writer_if.sv
// rtl/frame_buffer_writer_if.sv - Capture-side inputs and frame-buffer write/status outputs of frame_buffer_writer.
interface frame_buffer_writer_if #(
  parameter int ADDR_W = 19
);
  logic [15:0]       pixel_data;
  logic              pixel_valid;
  logic              frame_done;
  logic              continuous;
  logic              capture_start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              busy;
  logic              frame_written;
  logic              overflow;
  logic              short_frame;
  logic [7:0]        frame_count;

  modport master (
    output pixel_data, pixel_valid, frame_done, continuous, capture_start,
    input  wr_en, wr_addr, wr_data, busy, frame_written, overflow, short_frame, frame_count
  );

  modport slave (
    input  pixel_data, pixel_valid, frame_done, continuous, capture_start,
    output wr_en, wr_addr, wr_data, busy, frame_written, overflow, short_frame, frame_count
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - Writes frame-aligned RGB565 pixels as RGB444 into a frame buffer.
// Optional statistics (overflow, short_frame, frame_count) are built only with FBW_STATS_EN.
module frame_buffer_writer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic                 p_clock,
  input  logic                 reset,
  frame_buffer_writer_if.slave fb
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {IDLE, SYNC, WRITE} state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic             accept;
  logic [CNT_W-1:0] cnt_after;

  // A pixel arriving with frame_done still belongs to the ending frame.
  assign accept    = fb.pixel_valid && (pix_cnt < TOTAL);
  assign cnt_after = accept ? pix_cnt + CNT_W'(1) : pix_cnt;

  always_ff @(posedge p_clock) begin
    if (reset) begin
      state            <= IDLE;
      pix_cnt          <= '0;
      fb.wr_en         <= 1'b0;
      fb.wr_addr       <= '0;
      fb.wr_data       <= '0;
      fb.busy          <= 1'b0;
      fb.frame_written <= 1'b0;
    end else begin
      fb.wr_en         <= 1'b0;
      fb.frame_written <= 1'b0;
      case (state)
        IDLE: begin
          if (fb.continuous || fb.capture_start) begin
            state   <= SYNC;
            fb.busy <= 1'b1;
          end
        end
        SYNC: begin
          if (fb.frame_done) begin
            state   <= WRITE;
            pix_cnt <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            fb.wr_en   <= 1'b1;
            fb.wr_addr <= pix_cnt[ADDR_W-1:0];
            fb.wr_data <= {fb.pixel_data[15:12], fb.pixel_data[10:7], fb.pixel_data[4:1]};
          end
          if (fb.frame_done) begin
            fb.frame_written <= 1'b1;
            pix_cnt          <= '0;
            if (!fb.continuous) begin
              state   <= IDLE;
              fb.busy <= 1'b0;
            end
          end else begin
            pix_cnt <= cnt_after;
          end
        end
        default: begin
          state   <= IDLE;
          fb.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef FBW_STATS_EN
  always_ff @(posedge p_clock) begin
    if (reset) begin
      fb.overflow    <= 1'b0;
      fb.short_frame <= 1'b0;
      fb.frame_count <= 8'd0;
    end else if (state == WRITE) begin
      if (fb.pixel_valid && !accept) begin
        fb.overflow <= 1'b1;
      end
      if (fb.frame_done) begin
        fb.frame_count <= fb.frame_count + 8'd1;
        if (cnt_after < TOTAL) begin
          fb.short_frame <= 1'b1;
        end
      end
    end
  end
`else
  assign fb.overflow    = 1'b0;
  assign fb.short_frame = 1'b0;
  assign fb.frame_count = 8'd0;
`endif
endmodule
